// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: memory access codes,
// arbiter state codes and small decode helpers.
package dmem_arbiter_pkg;

  localparam logic [1:0] MEM_NONE     = 2'b00;
  localparam logic [1:0] MEM_BYTE     = 2'b01;
  localparam logic [1:0] MEM_HALFWORD = 2'b10;
  localparam logic [1:0] MEM_WORD     = 2'b11;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic logic is_access(input logic [1:0] code);
    return (code == MEM_WORD) || (code == MEM_HALFWORD) || (code == MEM_BYTE);
  endfunction

  // A length field of zero encodes a full 256-beat burst.
  function automatic logic [8:0] burst_len(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/dmem_burst_engine.sv
// Debug burst bookkeeping: current address, beats remaining, direction,
// and the registered read-data / read-valid / done strobes.
module dmem_burst_engine
  import dmem_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        start_i,
  input  logic        start_write_i,
  input  logic [7:0]  start_address_i,
  input  logic [7:0]  start_length_i,
  input  logic        beat_i,
  input  logic [31:0] mem_read_data_i,
  output logic [7:0]  address_o,
  output logic        write_o,
  output logic        last_o,
  output logic        done_o,
  output logic [31:0] read_data_o,
  output logic        read_valid_o
);

  logic [7:0]  address_q;
  logic [8:0]  remaining_q;
  logic        write_q;
  logic        done_q;
  logic [31:0] read_data_q;
  logic        read_valid_q;
  logic        last_s;

  assign last_s = (remaining_q == 9'd1);

  // Burst progress and per-beat result capture.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      address_q    <= 8'd0;
      remaining_q  <= 9'd0;
      write_q      <= 1'b0;
      done_q       <= 1'b0;
      read_data_q  <= 32'd0;
      read_valid_q <= 1'b0;
    end else begin
      done_q       <= beat_i & last_s;
      read_valid_q <= beat_i & ~write_q;
      if (beat_i && !write_q) begin
        read_data_q <= mem_read_data_i;
      end
      if (start_i) begin
        address_q   <= start_address_i;
        remaining_q <= burst_len(start_length_i);
        write_q     <= start_write_i;
      end else if (beat_i) begin
        address_q   <= address_q + 8'd1;
        remaining_q <= remaining_q - 9'd1;
      end
    end
  end

  assign address_o    = address_q;
  assign write_o      = write_q;
  assign last_o       = last_s;
  assign done_o       = done_q;
  assign read_data_o  = read_data_q;
  assign read_valid_o = read_valid_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM pipeline stage
// (priority) and a debug burst port with a bounded starvation limit.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [7:0]  pipe_address_i,
  input  logic [31:0] pipe_write_data_i,
  input  logic [1:0]  pipe_ctrl_mem_read_i,
  input  logic [1:0]  pipe_ctrl_mem_write_i,
  output logic [31:0] pipe_read_data_o,
  output logic        pipe_stall_o,
  input  logic        dbg_req_i,
  input  logic        dbg_write_i,
  input  logic [7:0]  dbg_address_i,
  input  logic [7:0]  dbg_length_i,
  input  logic [31:0] dbg_write_data_i,
  output logic        dbg_ack_o,
  output logic        dbg_beat_o,
  output logic [31:0] dbg_read_data_o,
  output logic        dbg_read_valid_o,
  output logic        dbg_done_o,
  output logic        dbg_busy_o,
  output logic [7:0]  mem_address_o,
  output logic [31:0] mem_write_data_o,
  output logic [1:0]  mem_ctrl_mem_read_o,
  output logic [1:0]  mem_ctrl_mem_write_o,
  input  logic [31:0] mem_read_data_i
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  arb_state_e  state_q;
  logic [3:0]  wait_cnt_q;
  logic        ack_q;
  logic        pipe_req_s;
  logic        dbg_grant_s;
  logic        start_s;
  logic [7:0]  eng_address_s;
  logic        eng_write_s;
  logic        eng_last_s;

  assign start_s = (state_q == ARB_IDLE) && dbg_req_i;

  // Grant decision: the pipe wins in BURST until the debug side has waited LIMIT cycles.
  always_comb begin
    pipe_req_s  = is_access(pipe_ctrl_mem_read_i) | is_access(pipe_ctrl_mem_write_i);
    dbg_grant_s = 1'b0;
    if (state_q == ARB_BURST) begin
      if (pipe_req_s && (wait_cnt_q < LIMIT_C)) begin
        dbg_grant_s = 1'b0;
      end else begin
        dbg_grant_s = 1'b1;
      end
    end else begin
      dbg_grant_s = 1'b0;
    end
  end

  // Memory-side mux: a debug beat always moves a full word.
  always_comb begin
    mem_address_o        = pipe_address_i;
    mem_write_data_o     = pipe_write_data_i;
    mem_ctrl_mem_read_o  = pipe_ctrl_mem_read_i;
    mem_ctrl_mem_write_o = pipe_ctrl_mem_write_i;
    if (dbg_grant_s) begin
      mem_address_o    = eng_address_s;
      mem_write_data_o = dbg_write_data_i;
      if (eng_write_s) begin
        mem_ctrl_mem_read_o  = MEM_NONE;
        mem_ctrl_mem_write_o = MEM_WORD;
      end else begin
        mem_ctrl_mem_read_o  = MEM_WORD;
        mem_ctrl_mem_write_o = MEM_NONE;
      end
    end else begin
      mem_address_o        = pipe_address_i;
      mem_write_data_o     = pipe_write_data_i;
      mem_ctrl_mem_read_o  = pipe_ctrl_mem_read_i;
      mem_ctrl_mem_write_o = pipe_ctrl_mem_write_i;
    end
  end

  assign pipe_stall_o     = dbg_grant_s & pipe_req_s;
  assign pipe_read_data_o = mem_read_data_i;
  assign dbg_beat_o       = dbg_grant_s;

  // Arbiter FSM with the starvation counter and the accept pulse.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= ARB_IDLE;
      wait_cnt_q <= 4'd0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (dbg_req_i) begin
            state_q    <= ARB_BURST;
            wait_cnt_q <= 4'd0;
            ack_q      <= 1'b1;
          end
        end
        ARB_BURST: begin
          if (dbg_grant_s) begin
            wait_cnt_q <= 4'd0;
            if (eng_last_s) begin
              state_q <= ARB_IDLE;
            end
          end else if (pipe_req_s) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          wait_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  assign dbg_ack_o  = ack_q;
  assign dbg_busy_o = (state_q == ARB_BURST);

  dmem_burst_engine u_engine (
    .clk_i           (clk_i),
    .n_rst_i         (n_rst_i),
    .start_i         (start_s),
    .start_write_i   (dbg_write_i),
    .start_address_i (dbg_address_i),
    .start_length_i  (dbg_length_i),
    .beat_i          (dbg_grant_s),
    .mem_read_data_i (mem_read_data_i),
    .address_o       (eng_address_s),
    .write_o         (eng_write_s),
    .last_o          (eng_last_s),
    .done_o          (dbg_done_o),
    .read_data_o     (dbg_read_data_o),
    .read_valid_o    (dbg_read_valid_o)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner cases
// and random traffic checked against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  pipe_address = 8'd0;
  logic [31:0] pipe_write_data = 32'd0;
  logic [1:0]  pipe_rd = 2'b00;
  logic [1:0]  pipe_wr = 2'b00;
  logic [31:0] pipe_read_data;
  logic        pipe_stall;
  logic        dbg_req = 1'b0;
  logic        dbg_write = 1'b0;
  logic [7:0]  dbg_address = 8'd0;
  logic [7:0]  dbg_length = 8'd0;
  logic [31:0] dbg_write_data = 32'd0;
  logic        dbg_ack, dbg_beat, dbg_read_valid, dbg_done, dbg_busy;
  logic [31:0] dbg_read_data;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_rd, mem_wr;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .n_rst_i(n_rst),
    .pipe_address_i(pipe_address), .pipe_write_data_i(pipe_write_data),
    .pipe_ctrl_mem_read_i(pipe_rd), .pipe_ctrl_mem_write_i(pipe_wr),
    .pipe_read_data_o(pipe_read_data), .pipe_stall_o(pipe_stall),
    .dbg_req_i(dbg_req), .dbg_write_i(dbg_write), .dbg_address_i(dbg_address),
    .dbg_length_i(dbg_length), .dbg_write_data_i(dbg_write_data),
    .dbg_ack_o(dbg_ack), .dbg_beat_o(dbg_beat), .dbg_read_data_o(dbg_read_data),
    .dbg_read_valid_o(dbg_read_valid), .dbg_done_o(dbg_done), .dbg_busy_o(dbg_busy),
    .mem_address_o(mem_address), .mem_write_data_o(mem_write_data),
    .mem_ctrl_mem_read_o(mem_rd), .mem_ctrl_mem_write_o(mem_wr),
    .mem_read_data_i(mem_read_data)
  );

  // Memory stand-in: combinational read, word writes land on the falling edge.
  logic [31:0] ram [256];
  logic        ram_clear = 1'b1;
  assign mem_read_data = ram[mem_address];
  always @(negedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
    end else if (mem_wr == MEM_WORD) begin
      ram[mem_address] <= mem_write_data;
    end
  end

  typedef struct {
    logic [1:0]  prd, pwr;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        dreq, dwr;
    logic [7:0]  daddr, dlen;
    logic [31:0] dwdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [5:0]  ef;    // {stall, beat, ack, done, read_valid, busy}
    logic        chkp;
    logic [31:0] eprd;
    logic [31:0] edrd;
  } vec_t;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  stim_t stim;

  // Reference model state: burst described as start address plus beats left.
  logic [31:0] mm [256];
  bit          m_busy, m_write, m_ack, m_done, m_rv;
  int          m_addr, m_left, m_wait;
  logic [31:0] m_rdata;
  bit          cur_beat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_write = 0; m_ack = 0; m_done = 0; m_rv = 0;
    m_addr = 0; m_left = 0; m_wait = 0; m_rdata = 32'd0;
  endtask

  task automatic model_check();
    bit preq;
    logic [7:0]  e_addr;
    logic [1:0]  e_rd, e_wr;
    logic [31:0] e_wd;
    preq = (stim.prd != MEM_NONE) || (stim.pwr != MEM_NONE);
    cur_beat = m_busy && !(preq && (m_wait < LIMIT));
    if (cur_beat) begin
      e_addr = 8'(m_addr);
      e_rd = m_write ? MEM_NONE : MEM_WORD;
      e_wr = m_write ? MEM_WORD : MEM_NONE;
      e_wd = stim.dwdata;
    end else begin
      e_addr = stim.paddr; e_rd = stim.prd; e_wr = stim.pwr; e_wd = stim.pwdata;
    end
    chk("stall", {31'd0, pipe_stall}, {31'd0, cur_beat && preq});
    chk("beat", {31'd0, dbg_beat}, {31'd0, cur_beat});
    chk("ack", {31'd0, dbg_ack}, {31'd0, m_ack});
    chk("done", {31'd0, dbg_done}, {31'd0, m_done});
    chk("read_valid", {31'd0, dbg_read_valid}, {31'd0, m_rv});
    chk("busy", {31'd0, dbg_busy}, {31'd0, m_busy});
    chk("dbg_rdata", dbg_read_data, m_rdata);
    chk("mem_addr", {24'd0, mem_address}, {24'd0, e_addr});
    chk("mem_rd", {30'd0, mem_rd}, {30'd0, e_rd});
    chk("mem_wr", {30'd0, mem_wr}, {30'd0, e_wr});
    chk("mem_wdata", mem_write_data, e_wd);
    if (!cur_beat && stim.prd != MEM_NONE) chk("pipe_rdata", pipe_read_data, mm[stim.paddr]);
  endtask

  task automatic model_update();
    bit preq;
    bit ack_n, done_n, rv_n;
    preq   = (stim.prd != MEM_NONE) || (stim.pwr != MEM_NONE);
    ack_n  = !m_busy && stim.dreq;
    done_n = cur_beat && (m_left == 1);
    rv_n   = cur_beat && !m_write;
    if (cur_beat && !m_write) m_rdata = mm[m_addr];
    if (cur_beat && m_write) mm[m_addr] = stim.dwdata;
    else if (!cur_beat && stim.pwr == MEM_WORD) mm[stim.paddr] = stim.pwdata;
    if (!m_busy) begin
      if (stim.dreq) begin
        m_busy = 1; m_write = stim.dwr; m_addr = stim.daddr; m_wait = 0;
        m_left = (stim.dlen == 8'd0) ? 256 : int'(stim.dlen);
      end
    end else if (cur_beat) begin
      m_addr = (m_addr + 1) % 256;
      m_left = m_left - 1;
      m_wait = 0;
      if (m_left == 0) m_busy = 0;
    end else if (preq) begin
      m_wait = m_wait + 1;
    end
    m_ack = ack_n; m_done = done_n; m_rv = rv_n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    pipe_rd = stim.prd; pipe_wr = stim.pwr; pipe_address = stim.paddr;
    pipe_write_data = stim.pwdata; dbg_req = stim.dreq; dbg_write = stim.dwr;
    dbg_address = stim.daddr; dbg_length = stim.dlen; dbg_write_data = stim.dwdata;
    #3;
    model_check();
    model_update();
  endtask

  task automatic stim_idle();
    stim = '{prd: MEM_NONE, pwr: MEM_NONE, paddr: 8'd0, pwdata: 32'd0,
             dreq: 1'b0, dwr: 1'b0, daddr: 8'd0, dlen: 8'd0, dwdata: 32'd0};
  endtask

  task automatic check_cleared();
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_beat", {31'd0, dbg_beat}, 32'd0);
    chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rst_done", {31'd0, dbg_done}, 32'd0);
    chk("rst_rv", {31'd0, dbg_read_valid}, 32'd0);
    chk("rst_busy", {31'd0, dbg_busy}, 32'd0);
    chk("rst_drdata", dbg_read_data, 32'd0);
    chk("rst_mem_ctrl", {28'd0, mem_rd, mem_wr}, 32'd0);
  endtask

  function automatic vec_t v(input logic [1:0] prd, input logic [1:0] pwr,
                             input logic [7:0] paddr, input logic [31:0] pwdata,
                             input logic dreq, input logic dwr, input logic [7:0] daddr,
                             input logic [7:0] dlen, input logic [31:0] dwdata,
                             input logic [5:0] ef, input logic chkp,
                             input logic [31:0] eprd, input logic [31:0] edrd);
    vec_t r;
    r.s = '{prd: prd, pwr: pwr, paddr: paddr, pwdata: pwdata, dreq: dreq, dwr: dwr,
            daddr: daddr, dlen: dlen, dwdata: dwdata};
    r.ef = ef; r.chkp = chkp; r.eprd = eprd; r.edrd = edrd;
    return r;
  endfunction

  localparam logic [1:0] W = MEM_WORD;
  localparam logic [1:0] N = MEM_NONE;

  vec_t tbl [24];

  initial begin
    int beats, dones, addr_err;
    tbl[0]  = v(N, W, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000000, 1'b0, 32'd0, 32'd0);
    tbl[1]  = v(W, N, 8'h10, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000000, 1'b1, 32'hDEADBEEF, 32'd0);
    tbl[2]  = v(N, N, 8'h00, 32'd0, 1'b1, 1'b1, 8'hFE, 8'd3, 32'd0, 6'b000000, 1'b0, 32'd0, 32'd0);
    tbl[3]  = v(N, N, 8'h00, 32'd0, 1'b0, 1'b1, 8'hFE, 8'd3, 32'd1, 6'b011001, 1'b0, 32'd0, 32'd0);
    tbl[4]  = v(N, N, 8'h00, 32'd0, 1'b0, 1'b1, 8'hFE, 8'd3, 32'd2, 6'b010001, 1'b0, 32'd0, 32'd0);
    tbl[5]  = v(N, N, 8'h00, 32'd0, 1'b0, 1'b1, 8'hFE, 8'd3, 32'd3, 6'b010001, 1'b0, 32'd0, 32'd0);
    tbl[6]  = v(N, N, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000100, 1'b0, 32'd0, 32'd0);
    tbl[7]  = v(W, N, 8'hFE, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000000, 1'b1, 32'd1, 32'd0);
    tbl[8]  = v(W, N, 8'hFF, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000000, 1'b1, 32'd2, 32'd0);
    tbl[9]  = v(W, N, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000000, 1'b1, 32'd3, 32'd0);
    tbl[10] = v(N, N, 8'h00, 32'd0, 1'b1, 1'b0, 8'hFE, 8'd2, 32'd0, 6'b000000, 1'b0, 32'd0, 32'd0);
    tbl[11] = v(N, N, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b011001, 1'b0, 32'd0, 32'd0);
    tbl[12] = v(N, N, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b010011, 1'b0, 32'd0, 32'd1);
    tbl[13] = v(N, N, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000110, 1'b0, 32'd0, 32'd2);
    tbl[14] = v(W, N, 8'h10, 32'd0, 1'b1, 1'b1, 8'h20, 8'd2, 32'd0, 6'b000000, 1'b1, 32'hDEADBEEF, 32'd0);
    tbl[15] = v(W, N, 8'h10, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b001001, 1'b1, 32'hDEADBEEF, 32'd0);
    tbl[16] = v(W, N, 8'h10, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000001, 1'b1, 32'hDEADBEEF, 32'd0);
    tbl[17] = v(W, N, 8'h10, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'hAA, 6'b110001, 1'b0, 32'd0, 32'd0);
    tbl[18] = v(W, N, 8'h10, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000001, 1'b1, 32'hDEADBEEF, 32'd0);
    tbl[19] = v(W, N, 8'h10, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000001, 1'b1, 32'hDEADBEEF, 32'd0);
    tbl[20] = v(W, N, 8'h10, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'hBB, 6'b110001, 1'b0, 32'd0, 32'd0);
    tbl[21] = v(W, N, 8'h10, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000100, 1'b1, 32'hDEADBEEF, 32'd0);
    tbl[22] = v(W, N, 8'h20, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000000, 1'b1, 32'hAA, 32'd0);
    tbl[23] = v(W, N, 8'h21, 32'd0, 1'b0, 1'b0, 8'h00, 8'd0, 32'd0, 6'b000000, 1'b1, 32'hBB, 32'd0);

    for (int i = 0; i < 256; i++) mm[i] = 32'd0;
    model_reset();
    stim_idle();
    #12;
    check_cleared();
    ram_clear = 1'b0;
    n_rst = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 24; i++) begin
      stim = tbl[i].s;
      step();
      chk($sformatf("vec%0d_flags", i),
          {26'd0, pipe_stall, dbg_beat, dbg_ack, dbg_done, dbg_read_valid, dbg_busy},
          {26'd0, tbl[i].ef});
      if (tbl[i].chkp) chk($sformatf("vec%0d_prdata", i), pipe_read_data, tbl[i].eprd);
      if (tbl[i].ef[1]) chk($sformatf("vec%0d_drdata", i), dbg_read_data, tbl[i].edrd);
    end

    // Length 0 read burst: 256 beats, address walks all the way round, one done.
    stim_idle();
    stim.dreq = 1'b1; stim.daddr = 8'h40; stim.dlen = 8'd0;
    step();
    stim.dreq = 1'b0;
    beats = 0; dones = 0; addr_err = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (dbg_done) dones++;
      if (dbg_beat) begin
        if (mem_address !== 8'(8'h40 + beats)) addr_err++;
        beats++;
      end
      if (dones != 0) break;
    end
    chk("len0_beats", beats, 256);
    chk("len0_dones", dones, 1);
    chk("len0_addr_err", addr_err, 0);
    step();
    chk("len0_single_done", {31'd0, dbg_done}, 32'd0);

    // Reset after two beats of a five-beat write burst.
    stim_idle();
    stim.dreq = 1'b1; stim.dwr = 1'b1; stim.daddr = 8'h80; stim.dlen = 8'd5;
    step();
    stim.dreq = 1'b0; stim.dwdata = 32'h1111;
    step();
    stim.dwdata = 32'h2222;
    step();
    stim_idle();
    #2 n_rst = 1'b0;
    #1 check_cleared();
    model_reset();
    @(posedge clk);
    #3 n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_no_done", {31'd0, dbg_done}, 32'd0);
    end
    stim.prd = W; stim.paddr = 8'h81;
    step();
    chk("post_rst_landed", pipe_read_data, 32'h2222);
    stim_idle();
    stim.dreq = 1'b1; stim.dwr = 1'b1; stim.daddr = 8'h90; stim.dlen = 8'd1;
    step();
    stim.dreq = 1'b0; stim.dwdata = 32'h3333;
    step();
    chk("post_rst_ack_beat", {30'd0, dbg_ack, dbg_beat}, 32'd3);
    stim_idle();
    step();
    chk("post_rst_done", {31'd0, dbg_done}, 32'd1);

    // Random mixed traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      stim.prd    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : MEM_NONE;
      stim.pwr    = (stim.prd == MEM_NONE && $urandom_range(0, 2) == 0) ? W : N;
      stim.paddr  = 8'($urandom_range(0, 15));
      stim.pwdata = $urandom;
      stim.dreq   = ($urandom_range(0, 3) == 0);
      stim.dwr    = 1'($urandom_range(0, 1));
      stim.daddr  = 8'($urandom_range(0, 15));
      stim.dlen   = 8'($urandom_range(1, 6));
      stim.dwdata = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 256-word data memory between the MEM pipeline stage and a debug/loader burst port.
- Sits between the MEM stage and the `memory` instance; the MEM stage connects to the pipe side and the memory connects to the mem side.
- The pipeline has priority. A starvation limit forces a debug beat and stalls the pipeline for one cycle.
- Debug accesses are word-only bursts with auto-incrementing address.

Parameters:
STARVE_LIMIT, 4, max consecutive cycles a pending debug beat yields to the pipeline (1..15)

Ports:
clk_i  in  1  clock, rising-edge state; memory writes land on the following falling edge
n_rst_i  in  1  reset, asynchronous, active-low
pipe_address_i  in  8  MEM-stage word address
pipe_write_data_i  in  32  MEM-stage store data
pipe_ctrl_mem_read_i  in  2  `WORD/`HALFWORD/`BYTE read; any other code = no read
pipe_ctrl_mem_write_i  in  2  same encoding, for writes
pipe_read_data_o  out  32  memory read data passed through to the MEM stage
pipe_stall_o  out  1  pipe access not performed this cycle; MEM stage must hold and re-present it
dbg_req_i  in  1  start-burst request, level
dbg_write_i  in  1  burst direction (1 = write)
dbg_address_i  in  8  burst start address
dbg_length_i  in  8  beat count; 0 means 256
dbg_write_data_i  in  32  write data, consumed in each dbg_beat_o cycle
dbg_ack_o  out  1  one-cycle pulse: request accepted
dbg_beat_o  out  1  debug beat performed this cycle (combinational)
dbg_read_data_o  out  32  registered read data
dbg_read_valid_o  out  1  dbg_read_data_o valid, one cycle
dbg_done_o  out  1  one-cycle pulse after the last beat
dbg_busy_o  out  1  burst in progress
mem_address_o  out  8  to memory.address_i
mem_write_data_o  out  32  to memory.write_data_i
mem_ctrl_mem_read_o  out  2  to memory.ctrl_mem_read_i
mem_ctrl_mem_write_o  out  2  to memory.ctrl_mem_write_i
mem_read_data_i  in  32  from memory.read_data_o

Behaviour:
- Reset (async, n_rst_i low): state IDLE; all registered outputs and counters 0. Consequences:
  - ack, done, read_valid and busy are 0; dbg_read_data_o is 0.
  - Combinational outputs idle: mem ctrl = no-access code, dbg_beat_o = 0, pipe_stall_o = 0.
  - Reset mid-burst abandons the burst silently: no done pulse. Writes already landed persist.
- pipe_req = pipe read ctrl or pipe write ctrl is a valid access code.
- IDLE state:
  - Pipe is always granted; mem_* mirror pipe_* combinationally.
  - pipe_read_data_o = mem_read_data_i.
  - dbg_req_i=1 at a rising edge:
    - latch address, direction and remaining length (9-bit; 0 becomes 256);
    - clear wait_cnt;
    - assert dbg_ack_o for the next cycle;
    - go to BURST.
- BURST state, each cycle:
  - If pipe_req and wait_cnt < STARVE_LIMIT: pipe is granted, wait_cnt is incremented, and dbg_beat_o = 0.
  - Otherwise a debug beat runs:
    - mem_address_o = current address; the active direction's ctrl = `WORD and the other = no-access.
    - dbg_beat_o = 1, and pipe_stall_o = pipe_req.
    - At the edge: address += 1 (wraps 255 to 0), remaining -= 1, wait_cnt = 0.
    - For a read beat, mem_read_data_i is registered into dbg_read_data_o and dbg_read_valid_o is high the next cycle.
- Consecutive stalls are impossible: after a forced beat wait_cnt = 0, so the pipe wins the next cycle.
- Last beat (remaining = 1):
  - go to IDLE at the edge;
  - dbg_done_o pulses the next cycle, coincident with the final dbg_read_valid_o on reads.
- dbg_busy_o = 1 while in BURST.
- dbg_req_i while busy is ignored. A request held through done is accepted no earlier than the first IDLE cycle, so acks are never back-to-back with a beat.
- When pipe_req = 0 while not granted: pipe_read_data_o is don't-care, driven as mem_read_data_i.
- Total latency for an N-beat burst with no contention: ack at cycle 1, beats at cycles 1..N, done at cycle N+1.

Decomposition:
- header.v additions:
  - `MEM_NONE 2'b00 as the canonical no-access code, alongside `WORD/`HALFWORD/`BYTE;
  - `ARB_IDLE and `ARB_BURST state codes.
- One sub-module, dmem_burst_engine: holds address, remaining, direction, done/last flags, and takes a beat strobe.
- The top level holds the grant decision, wait_cnt, and the muxes.

Test Plan:
- Reset then a pipe-only sequence (STARVE_LIMIT=4):
  - pipe word write 0xDEADBEEF to addr 0x10, then a read -> pipe_read_data_o = 0xDEADBEEF;
  - stall never asserted; all dbg outputs 0.
- Debug write burst: addr 0xFE, length 3, data 1, 2, 3, no pipe traffic.
  - Expected: ack, then beats to 0xFE, 0xFF, 0x00; done one cycle after the third beat.
  - Pipe reads afterwards return 1, 2, 3.
- Debug read burst of 2 from 0xFE -> dbg_read_valid_o on 2 consecutive cycles with 1 then 2; done coincident with the second valid.
- Contention: STARVE_LIMIT=2, pipe_req held high, debug length 2.
  - Grant pattern P, P, D, P, P, D.
  - pipe_stall_o high exactly on the D cycles; done after the second D.
- Length 0 -> exactly 256 beats; address returns to start; single done pulse.
- n_rst_i low mid-burst after 2 of 5 beats:
  - outputs cleared immediately; no done;
  - a new request after release is accepted normally.
